mem_port_arbiter: RTL and testbench

//  Sits between the microprocessor data-memory interface and the single-port RAM.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port indices and the
// fixed-priority selector used to pick the next pending request.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // 0 = write port, 1..4 = read ports 1..4
  typedef logic [2:0] port_t;
  localparam port_t PORT_WR = 3'd0;

  // pend layout is {wr, rd4, rd3, rd2, rd1}; the write always wins.
  function automatic port_t pick_next(input logic [4:0] pend);
    port_t p;
    if (pend[4]) begin
      p = 3'd0;
    end else if (pend[0]) begin
      p = 3'd1;
    end else if (pend[1]) begin
      p = 3'd2;
    end else if (pend[2]) begin
      p = 3'd3;
    end else if (pend[3]) begin
      p = 3'd4;
    end else begin
      p = PORT_WR;
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises one write port and four read ports of the core onto a single-port
// RAM, stalling the core until the whole request bundle has been served.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [3:0]        rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  input  logic [ADDR_W-1:0] rd_addr3_i,
  input  logic [ADDR_W-1:0] rd_addr4_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic [DATA_W-1:0] rd_data3_o,
  output logic [DATA_W-1:0] rd_data4_o,
  output logic              in_ready_o,
  output logic [3:0]        out_ready_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_indata_o,
  output logic              ram_write_o,
  output logic              ram_read_o,
  input  logic [DATA_W-1:0] ram_outdata_i
);

  localparam int LW = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

  state_t                  state_q, state_d;
  logic [4:0]              pend_q, pend_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [3:0][ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [3:0][DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [1:0]              cur_q, cur_d;
  logic [LW-1:0]           lat_cnt_q, lat_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic [3:0]              out_ready_q, out_ready_d;
  logic                    ram_write_q, ram_write_d;
  logic                    ram_read_q, ram_read_d;
  logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]       ram_indata_q, ram_indata_d;

  logic  any_req_s;
  port_t sel_s;
  logic [1:0] idx_s;

  assign any_req_s = wr_en_i | (|rd_en_i);
  assign sel_s     = pick_next(pend_q);
  assign idx_s     = 2'(sel_s - 3'd1);
  assign stall_o   = ((state_q == IDLE) && any_req_s) || (state_q == ISSUE) || (state_q == WAIT);

  // Next-state, bundle latch and RAM strobe decode.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    cur_d        = cur_q;
    lat_cnt_d    = lat_cnt_q;
    in_ready_d   = 1'b0;
    out_ready_d  = 4'b0000;
    ram_write_d  = 1'b0;
    ram_read_d   = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_indata_d = ram_indata_q;

    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          pend_d    = {wr_en_i, rd_en_i};
          wr_addr_d = wr_addr_i;
          wr_data_d = wr_data_i;
          rd_addr_d = {rd_addr4_i, rd_addr3_i, rd_addr2_i, rd_addr1_i};
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (pend_q == 5'd0) begin
          state_d = DONE;
        end else if (sel_s == PORT_WR) begin
          pend_d[4]    = 1'b0;
          ram_write_d  = 1'b1;
          ram_addr_d   = wr_addr_q;
          ram_indata_d = wr_data_q;
          in_ready_d   = 1'b1;
          state_d      = (pend_q[3:0] != 4'd0) ? ISSUE : DONE;
        end else begin
          pend_d[idx_s] = 1'b0;
          ram_read_d    = 1'b1;
          ram_addr_d    = rd_addr_q[idx_s];
          lat_cnt_d     = LW'(RAM_LAT);
          cur_d         = idx_s;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        // pend_q already excludes the read in flight
        if (lat_cnt_q == LW'(1)) begin
          rd_data_d[cur_q]   = ram_outdata_i;
          out_ready_d[cur_q] = 1'b1;
          state_d            = (pend_q != 5'd0) ? ISSUE : DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any bundle in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pend_q       <= 5'd0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      cur_q        <= 2'd0;
      lat_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      out_ready_q  <= 4'b0000;
      ram_write_q  <= 1'b0;
      ram_read_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_indata_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      cur_q        <= cur_d;
      lat_cnt_q    <= lat_cnt_d;
      in_ready_q   <= in_ready_d;
      out_ready_q  <= out_ready_d;
      ram_write_q  <= ram_write_d;
      ram_read_q   <= ram_read_d;
      ram_addr_q   <= ram_addr_d;
      ram_indata_q <= ram_indata_d;
    end
  end

  assign rd_data1_o   = rd_data_q[0];
  assign rd_data2_o   = rd_data_q[1];
  assign rd_data3_o   = rd_data_q[2];
  assign rd_data4_o   = rd_data_q[3];
  assign in_ready_o   = in_ready_q;
  assign out_ready_o  = out_ready_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_indata_o = ram_indata_q;
  assign ram_write_o  = ram_write_q;
  assign ram_read_o   = ram_read_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a RAM_LAT=1 instance carries the main
// scenarios and a RAM_LAT=3 instance checks the longer read latency.
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 10;
  localparam logic [DW-1:0] POISON = 10'h3FF;

  typedef struct {
    logic          is_wr;
    logic [1:0]    port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RAM_LAT=1 instance signals
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    rd_en;
  logic [AW-1:0] rd_a [4];
  logic [DW-1:0] rd_d [4];
  logic          in_ready, stall, ram_write, ram_read;
  logic [3:0]    out_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_indata, ram_outdata;

  // RAM_LAT=3 instance signals
  logic [3:0]    l3_rd_en;
  logic [AW-1:0] l3_rd_a [4];
  logic [DW-1:0] l3_rd_d [4];
  logic          l3_in_ready, l3_stall, l3_ram_write, l3_ram_read;
  logic [3:0]    l3_out_ready;
  logic [AW-1:0] l3_ram_addr;
  logic [DW-1:0] l3_ram_indata, l3_ram_outdata;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  op_t q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_rd [4];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_addr1_i(rd_a[0]), .rd_addr2_i(rd_a[1]), .rd_addr3_i(rd_a[2]), .rd_addr4_i(rd_a[3]),
    .rd_data1_o(rd_d[0]), .rd_data2_o(rd_d[1]), .rd_data3_o(rd_d[2]), .rd_data4_o(rd_d[3]),
    .in_ready_o(in_ready), .out_ready_o(out_ready), .stall_o(stall),
    .ram_addr_o(ram_addr), .ram_indata_o(ram_indata), .ram_write_o(ram_write),
    .ram_read_o(ram_read), .ram_outdata_i(ram_outdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(1'b0), .wr_addr_i(14'd0), .wr_data_i(10'd0), .rd_en_i(l3_rd_en),
    .rd_addr1_i(l3_rd_a[0]), .rd_addr2_i(l3_rd_a[1]), .rd_addr3_i(l3_rd_a[2]), .rd_addr4_i(l3_rd_a[3]),
    .rd_data1_o(l3_rd_d[0]), .rd_data2_o(l3_rd_d[1]), .rd_data3_o(l3_rd_d[2]), .rd_data4_o(l3_rd_d[3]),
    .in_ready_o(l3_in_ready), .out_ready_o(l3_out_ready), .stall_o(l3_stall),
    .ram_addr_o(l3_ram_addr), .ram_indata_o(l3_ram_indata), .ram_write_o(l3_ram_write),
    .ram_read_o(l3_ram_read), .ram_outdata_i(l3_ram_outdata)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return 10'(a * 7 + 3) ^ 10'h15A;
  endfunction

  // RAM models: data is only valid RAM_LAT-1 cycles after the ram_read cycle.
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p0, p1;

  always @(posedge clk) begin
    if (ram_write) mem1[ram_addr] <= ram_indata;
  end
  assign ram_outdata = ram_read ? mem1[ram_addr] : POISON;

  always @(posedge clk) begin
    if (l3_ram_write) mem3[l3_ram_addr] <= l3_ram_indata;
    p0 <= l3_ram_read ? mem3[l3_ram_addr] : POISON;
    p1 <= p0;
  end
  assign l3_ram_outdata = p1;

  // Scoreboard monitor for the RAM_LAT=1 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_write && ram_read) begin
        checks++; errors++;
        $display("FAIL strobes_exclusive: ram_write=%b ram_read=%b, required not both 1", ram_write, ram_read);
      end
      if (ram_write || in_ready) begin
        checks++;
        if (q.size() == 0 || !q[0].is_wr || !ram_write || !in_ready) begin
          errors++;
          $display("FAIL write_issue: ram_write=%b in_ready=%b addr=%h, no matching expected write", ram_write, in_ready, ram_addr);
        end else begin
          if (ram_addr !== q[0].addr || ram_indata !== q[0].data) begin
            errors++;
            $display("FAIL write_op: addr=%h data=%h, required addr=%h data=%h", ram_addr, ram_indata, q[0].addr, q[0].data);
          end
          void'(q.pop_front());
        end
      end
      if (ram_read) begin
        rd_pulses++;
        checks++;
        if (q.size() == 0 || q[0].is_wr) begin
          errors++;
          $display("FAIL read_issue: ram_read at addr=%h with no expected read at head", ram_addr);
        end else if (ram_addr !== q[0].addr) begin
          errors++;
          $display("FAIL read_addr: addr=%h, required %h (port %0d)", ram_addr, q[0].addr, q[0].port + 1);
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (out_ready[p]) begin
          checks++;
          if (q.size() == 0 || q[0].is_wr || q[0].port != 2'(p)) begin
            errors++;
            $display("FAIL out_ready_order: out_ready[%0d] pulsed, no matching expected read", p);
          end else begin
            if (rd_d[p] !== q[0].data) begin
              errors++;
              $display("FAIL rd_data%0d: got %h, required %h", p + 1, rd_d[p], q[0].data);
            end
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_bundle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [3:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    logic [AW-1:0] aa [4];
    aa = '{a0, a1, a2, a3};
    wr_en = w; wr_addr = wa; wr_data = wd; rd_en = re;
    for (int p = 0; p < 4; p++) rd_a[p] = aa[p];
    if (w) begin
      q.push_back('{is_wr: 1'b1, port: 2'd0, addr: wa, data: wd});
      ref_mem[wa] = wd;
    end
    for (int p = 0; p < 4; p++) begin
      if (re[p]) begin
        q.push_back('{is_wr: 1'b0, port: 2'(p), addr: aa[p], data: ref_mem[aa[p]]});
        exp_rd[p] = ref_mem[aa[p]];
      end
    end
  endtask

  task automatic drop_inputs();
    wr_en = 1'b0; rd_en = 4'b0000;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 after DONE.
  task automatic run_bundle(input string name, input logic w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic [3:0] re,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                            input int exp_stall, input bit hold);
    int cnt;
    push_bundle(w, wa, wd, re, a0, a1, a2, a3);
    cnt = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (stall) cnt++;
      else break;
    end
    checks++;
    if (cnt !== exp_stall) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d, required %0d", name, cnt, exp_stall);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_d[p] !== exp_rd[p]) begin
        errors++;
        $display("FAIL %s_rd_data%0d_at_done: got %h, required %h", name, p + 1, rd_d[p], exp_rd[p]);
      end
    end
    if (!hold) drop_inputs();
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_scoreboard_drain: %0d ops still expected, required 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({stall, ram_write, ram_read, in_ready, out_ready} !== 8'd0 || ram_addr !== 14'd0 || ram_indata !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl: stall=%b wr=%b rd=%b in=%b out=%b addr=%h, required all 0",
               stall, ram_write, ram_read, in_ready, out_ready, ram_addr);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_d[p] !== 10'd0 || l3_rd_d[p] !== 10'd0) begin
        errors++;
        $display("FAIL reset_rd_data%0d: got %h/%h, required 000", p + 1, rd_d[p], l3_rd_d[p]);
      end
    end
    checks++;
    if ({l3_stall, l3_ram_write, l3_ram_read, l3_in_ready, l3_out_ready} !== 8'd0 || l3_ram_indata !== 10'd0) begin
      errors++;
      $display("FAIL reset_lat3_ctrl: stall=%b wr=%b rd=%b, required all 0", l3_stall, l3_ram_write, l3_ram_read);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_only();
    run_bundle("t1", 1'b1, 14'h0010, 10'h155, 4'b0000, 14'd0, 14'd0, 14'd0, 14'd0, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ram_addr !== 14'h0010 || ram_indata !== 10'h155) begin
      errors++;
      $display("FAIL t1_ram_hold: addr=%h data=%h, required 0010/155", ram_addr, ram_indata);
    end
  endtask

  task automatic test_single_read();
    run_bundle("t2", 1'b0, 14'd0, 10'd0, 4'b0001, 14'h0010, 14'd0, 14'd0, 14'd0, 3, 1'b0);
  endtask

  task automatic test_full_bundle();
    run_bundle("t3", 1'b1, 14'h0020, 10'h0AA, 4'b1111, 14'h0020, 14'h0020, 14'h0020, 14'h0020, 10, 1'b0);
    run_bundle("mix", 1'b0, 14'd0, 10'd0, 4'b1010, 14'h0000, 14'h0077, 14'h0000, 14'h0010, 5, 1'b0);
  endtask

  task automatic test_lat3();
    int cnt, rr, oo;
    cnt = 0; rr = -1; oo = -1;
    l3_rd_en = 4'b0100;
    l3_rd_a[2] = 14'h0123;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (l3_ram_read) rr = c;
      if (l3_out_ready[2]) oo = c;
      if (l3_stall) cnt++;
      else break;
    end
    l3_rd_en = 4'b0000;
    checks++;
    if (cnt !== 5) begin
      errors++;
      $display("FAIL t4_stall_cycles: got %0d, required 5", cnt);
    end
    checks++;
    if (rr < 0 || oo - rr !== 3) begin
      errors++;
      $display("FAIL t4_read_to_ready: read at %0d ready at %0d, required distance 3", rr, oo);
    end
    checks++;
    if (l3_rd_d[2] !== pat(14'h0123) || l3_rd_d[0] !== 10'd0 || l3_rd_d[1] !== 10'd0 || l3_rd_d[3] !== 10'd0) begin
      errors++;
      $display("FAIL t4_rd_data: got %h %h %h %h, required 000 000 %h 000",
               l3_rd_d[0], l3_rd_d[1], l3_rd_d[2], l3_rd_d[3], pat(14'h0123));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_bundle();
    bit pulsed;
    push_bundle(1'b1, 14'h0030, 10'h2CC, 4'b1111, 14'h0030, 14'h0030, 14'h0030, 14'h0030);
    repeat (4) @(negedge clk);
    checks++;
    if (stall !== 1'b1 || ram_read !== 1'b1) begin
      errors++;
      $display("FAIL t5_in_wait: stall=%b ram_read=%b, required 1/1", stall, ram_read);
    end
    rst = 1'b1;
    drop_inputs();
    #1;
    checks++;
    if ({stall, ram_write, ram_read, in_ready, out_ready} !== 8'd0 || ram_addr !== 14'd0) begin
      errors++;
      $display("FAIL t5_async_clear: stall=%b wr=%b rd=%b out=%b addr=%h, required 0",
               stall, ram_write, ram_read, out_ready, ram_addr);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_d[p] !== 10'd0) begin
        errors++;
        $display("FAIL t5_rd_data%0d_clear: got %h, required 000", p + 1, rd_d[p]);
      end
      exp_rd[p] = 10'd0;
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulsed = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_ready !== 4'd0 || stall !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL t5_no_late_pulse: activity after reset release, required none");
    end
    @(posedge clk); #1;
    run_bundle("t5_reissue", 1'b1, 14'h0030, 10'h2CC, 4'b1111, 14'h0030, 14'h0030, 14'h0030, 14'h0030, 10, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit busy;
    rd_pulses = 0;
    run_bundle("t6_first", 1'b0, 14'd0, 10'd0, 4'b0010, 14'd0, 14'h0077, 14'd0, 14'd0, 3, 1'b1);
    run_bundle("t6_second", 1'b0, 14'd0, 10'd0, 4'b0010, 14'd0, 14'h0077, 14'd0, 14'd0, 3, 1'b0);
    busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (stall) busy = 1'b1;
    end
    checks++;
    if (rd_pulses !== 2 || busy) begin
      errors++;
      $display("FAIL t6_single_restart: %0d reads busy=%b, required 2 reads and idle", rd_pulses, busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem1[i] = pat(i);
      mem3[i] = pat(i);
      ref_mem[i] = pat(i);
    end
    for (int p = 0; p < 4; p++) begin
      rd_a[p] = 14'd0;
      l3_rd_a[p] = 14'd0;
      exp_rd[p] = 10'd0;
    end
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = 14'd0; wr_data = 10'd0; rd_en = 4'b0000;
    l3_rd_en = 4'b0000;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_only();
    test_single_read();
    test_full_bundle();
    test_lat3();
    test_reset_mid_bundle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
